rs485_uart_link: RTL and testbench
==================================

# rs485_uart_link

Half-duplex 8N1 UART transceiver driving the on-board RS485 transceiver used to program the motor drivers over the GBT slow-control path. It serializes command bytes onto the RS485 driver input with driver-enable framing, and receives reply bytes from the receiver output with mid-bit sampling and framing-error detection. It sits between the page-selector/serial-register command path (upstream) and the `rs485_x` pins (downstream). Received bytes are returned through the readback mux.

## Interface
Parameters:
- `g_ClkDiv`, 347, clock cycles per bit; 40 MHz / 347 gives roughly 115.2 kBd; legal range 4 or more.
- `g_Guard`, 1, bit times of driver-enable lead before the start bit and trail after the stop bit; legal range 0 to 3.

Ports:
- `ClkRs_ix.clk`, input, 1, block clock. Connected to the GBT frame-clock `ckrs_t` bundle.
- `ClkRs_ix.reset`, input, 1, reset. Asynchronous, active-high.
- `data_ib8`, input, 8, byte to transmit. Sampled on the cycle it is accepted.
- `txstart_i`, input, 1, transmit request. Accepted only while `txbusy_o` is 0.
- `txbusy_o`, output, 1, high while a transmit frame including guard time is in progress.
- `Tx_o`, output, 1, serial output to `rs485_pl_di`. Idles at 1.
- `de_o`, output, 1, RS485 driver enable.
- `Rx_i`, input, 1, serial input from `rs485_pl_ro`. Asynchronous to the clock.
- `data_ob8`, output, 8, last correctly received byte.
- `newdata_o`, output, 1, one-cycle pulse when `data_ob8` is updated.
- `rxerror_o`, output, 1, one-cycle pulse on a framing error.

## Operation
- Reset values:
  - `Tx_o` = 1.
  - `de_o`, `txbusy_o`, `newdata_o` and `rxerror_o` = 0.
  - `data_ob8` = 8'h00.
  - Both FSMs go to IDLE. The divider and bit counters clear.
- TX FSM states: IDLE, LEAD, START, DATA, STOP, TRAIL.
  - IDLE: if `txstart_i` is 1, latch `data_ib8` and go to LEAD. If `g_Guard` = 0, go directly to START.
  - LEAD: lasts `g_Guard` bit times, with `de_o` = 1 and `Tx_o` = 1.
  - START: lasts one bit time with `Tx_o` = 0.
  - DATA: 8 bit times, LSB first.
  - STOP: one bit time with `Tx_o` = 1.
  - TRAIL: lasts `g_Guard` bit times with `de_o` = 1, then returns to IDLE.
- `de_o` and `txbusy_o` are 1 in every TX state except IDLE.
- `txstart_i` while `txbusy_o` is 1 is ignored. It is not queued.
- Counters:
  - Bit divider: width $clog2(`g_ClkDiv`). It counts 0 to `g_ClkDiv`-1 and wraps; a bit boundary occurs at the wrap.
  - Bit counter: 4 bits.
- RX path:
  - `Rx_i` passes through a 2-FF synchronizer before use.
  - RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a synchronized falling edge moves to START and loads the divider.
  - START: at `g_ClkDiv`/2 cycles (integer division), re-sample the line. If it is 1, treat the edge as a glitch and return to IDLE with no pulse. If it is 0, go to DATA.
  - DATA: sample each bit every `g_ClkDiv` cycles, shifting in LSB first.
  - STOP: sample the stop bit. If it is 1, update `data_ob8` and pulse `newdata_o`. If it is 0, pulse `rxerror_o` and leave `data_ob8` unchanged. In both cases return to IDLE immediately, so a new start edge may be detected during the remainder of the stop bit.
- Echo suppression: the RX FSM is held in IDLE while `de_o` is 1, and for 2 cycles after `de_o` falls (synchronizer flush). Edges in that window are discarded.
- TX and RX are otherwise independent. A transmit request during reception aborts reception: the RX FSM goes to IDLE with no pulse.

## Timing
- Accept on cycle N:
  - `txbusy_o` and `de_o` rise at N+1.
  - The start bit begins at N+1+`g_Guard`·`g_ClkDiv`.
  - `txbusy_o` falls at N+1+(10+2·`g_Guard`)·`g_ClkDiv`.
  - The earliest next accept is on that same cycle.
- `Tx_o` and `de_o` are registered outputs with no combinational path from the inputs.
- RX latency: `newdata_o` and `rxerror_o` assert 2 (synchronizer) + 1 + (9·`g_ClkDiv` + `g_ClkDiv`/2) cycles after the falling edge on `Rx_i`, within ±1 cycle due to synchronizer phase.
- `data_ob8` changes in the same cycle that `newdata_o` is 1, and holds until the next good frame.
- Reset mid-frame: all outputs return to their reset values asynchronously. A partial byte is never emitted.

## Test plan
- `g_ClkDiv`=4, `g_Guard`=1. Send 8'hA5. Required response:
  - `Tx_o` carries 0,1,0,1,0,0,1,0,1,1 (start, data LSB first, stop), each bit held 4 cycles.
  - `de_o` is high for 48 cycles.
  - `txbusy_o` is high for 48 cycles.
- Drive an 8'h3C frame on `Rx_i`. Required response: one `newdata_o` pulse, `data_ob8` = 8'h3C, no `rxerror_o`.
- Drive an 8'h3C frame with stop bit = 0. Required response: one `rxerror_o` pulse, `data_ob8` keeps its previous value, no `newdata_o`.
- Drive a 1-cycle low glitch on idle `Rx_i`. Required response: no pulses, and the RX FSM is back in IDLE by `g_ClkDiv`/2+3 cycles.
- Pulse `txstart_i` with 8'h11 while busy sending 8'h22, with `Rx_i` looped to `Tx_o`. Required response: only 8'h22 is transmitted, and the echo produces no `newdata_o`.
- Assert reset in the middle of the DATA bit-3 phase. Required response: `Tx_o`=1, `de_o`=0, `txbusy_o`=0 immediately. After reset release, a new 8'h5A is sent correctly.

Source files
------------

// File: rtl/rs485_uart_link.sv
// rs485_uart_link
// Half-duplex 8N1 UART transceiver for the on-board RS485 driver used to
// program the motor drivers over the GBT slow-control path.
//
// Ports:
//   ClkRs_ix   : clock / asynchronous active-high reset bundle (ckrs_t)
//   data_ib8   : byte to transmit, captured when txstart_i is accepted
//   txstart_i  : transmit request, honoured only while txbusy_o is 0
//   txbusy_o   : high for the whole transmit frame including guard time
//   Tx_o       : serial output to rs485_pl_di (idles high, registered)
//   de_o       : RS485 driver enable (registered)
//   Rx_i       : serial input from rs485_pl_ro (asynchronous)
//   data_ob8   : last correctly received byte
//   newdata_o  : one-cycle pulse when data_ob8 is updated
//   rxerror_o  : one-cycle pulse on a framing error (stop bit low)

typedef struct packed {
  logic clk;
  logic reset;
} ckrs_t;

module rs485_uart_link #(
  parameter int g_ClkDiv = 347,
  parameter int g_Guard  = 1
) (
  input  ckrs_t      ClkRs_ix,
  input  logic [7:0] data_ib8,
  input  logic       txstart_i,
  output logic       txbusy_o,
  output logic       Tx_o,
  output logic       de_o,
  input  logic       Rx_i,
  output logic [7:0] data_ob8,
  output logic       newdata_o,
  output logic       rxerror_o
);

  localparam int               DIV_W       = $clog2(g_ClkDiv);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(g_ClkDiv - 1);
  // START ends after g_ClkDiv/2 cycles; the divider starts at 0 on entry.
  localparam logic [DIV_W-1:0] DIV_HALF_M1 = DIV_W'(g_ClkDiv / 2 - 1);
  localparam logic [3:0]       GUARD_LAST  = (g_Guard > 0) ? 4'(g_Guard - 1) : 4'd0;

  logic clk;
  logic rst;
  assign clk = ClkRs_ix.clk;
  assign rst = ClkRs_ix.reset;

  // ------------------------------------------------------------------
  // Transmitter
  // ------------------------------------------------------------------
  typedef enum logic [2:0] {
    TX_IDLE, TX_LEAD, TX_START, TX_DATA, TX_STOP, TX_TRAIL
  } tx_state_t;

  tx_state_t        tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_div_q, tx_div_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic             tx_q, tx_d;
  logic             de_q, de_d;
  logic             tx_wrap;
  logic             tx_accept;

  assign tx_wrap   = (tx_div_q == DIV_LAST);
  assign tx_accept = (tx_state_q == TX_IDLE) && txstart_i;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_div_d   = tx_wrap ? '0 : tx_div_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_div_d = '0;
        tx_bit_d = '0;
        if (txstart_i) begin
          tx_sh_d    = data_ib8;
          tx_state_d = (g_Guard == 0) ? TX_START : TX_LEAD;
        end
      end
      TX_LEAD: begin
        if (tx_wrap) begin
          if (tx_bit_q == GUARD_LAST) begin
            tx_state_d = TX_START;
            tx_bit_d   = '0;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
      TX_START: begin
        if (tx_wrap) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = '0;
        end
      end
      TX_DATA: begin
        if (tx_wrap) begin
          tx_sh_d = {1'b0, tx_sh_q[7:1]};
          if (tx_bit_q == 4'd7) begin
            tx_state_d = TX_STOP;
            tx_bit_d   = '0;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
      TX_STOP: begin
        if (tx_wrap) begin
          tx_state_d = (g_Guard == 0) ? TX_IDLE : TX_TRAIL;
          tx_bit_d   = '0;
        end
      end
      TX_TRAIL: begin
        if (tx_wrap) begin
          if (tx_bit_q == GUARD_LAST) begin
            tx_state_d = TX_IDLE;
            tx_bit_d   = '0;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // Line outputs are derived from the next state so that the registered
    // pins change exactly with the state register.
    tx_d = 1'b1;
    if (tx_state_d == TX_START) begin
      tx_d = 1'b0;
    end else if (tx_state_d == TX_DATA) begin
      tx_d = tx_sh_d[0];
    end
    de_d = (tx_state_d != TX_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_div_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
      de_q       <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
      de_q       <= de_d;
    end
  end

  assign Tx_o     = tx_q;
  assign de_o     = de_q;
  assign txbusy_o = (tx_state_q != TX_IDLE);

  // ------------------------------------------------------------------
  // Receiver
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  rx_state_t        rx_state_q, rx_state_d;
  logic [DIV_W-1:0] rx_div_q, rx_div_d;
  logic [3:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_nd_q, rx_nd_d;
  logic             rx_err_q, rx_err_d;
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]       rx_hold_q, rx_hold_d;
  logic             rx_block;
  logic             rx_fall;
  logic             rx_wrap;

  // Hold-off keeps the receiver deaf to our own echo until the
  // synchronizer has flushed the last driven level.
  assign rx_hold_d = de_q ? 2'd2 : ((rx_hold_q != 2'd0) ? rx_hold_q - 2'd1 : 2'd0);
  assign rx_block  = de_q || (rx_hold_q != 2'd0) || tx_accept;
  assign rx_fall   = rx_prev_q && !rx_sync_q;
  assign rx_wrap   = (rx_div_q == DIV_LAST);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_div_d   = rx_div_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_nd_d    = 1'b0;
    rx_err_d   = 1'b0;
    if (rx_block) begin
      rx_state_d = RX_IDLE;
      rx_div_d   = '0;
      rx_bit_d   = '0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          rx_div_d = '0;
          rx_bit_d = '0;
          if (rx_fall) rx_state_d = RX_START;
        end
        RX_START: begin
          if (rx_div_q == DIV_HALF_M1) begin
            rx_div_d   = '0;
            // Line back high at mid start bit: it was a glitch.
            rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_wrap) begin
            rx_div_d = '0;
            rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
            if (rx_bit_q == 4'd7) begin
              rx_state_d = RX_STOP;
              rx_bit_d   = '0;
            end else begin
              rx_bit_d = rx_bit_q + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (rx_wrap) begin
            rx_div_d   = '0;
            rx_state_d = RX_IDLE;
            if (rx_sync_q) begin
              rx_data_d = rx_sh_q;
              rx_nd_d   = 1'b1;
            end else begin
              rx_err_d = 1'b1;
            end
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_hold_q  <= 2'd0;
      rx_state_q <= RX_IDLE;
      rx_div_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_nd_q    <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_meta_q  <= Rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_hold_q  <= rx_hold_d;
      rx_state_q <= rx_state_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_nd_q    <= rx_nd_d;
      rx_err_q   <= rx_err_d;
    end
  end

  assign data_ob8  = rx_data_q;
  assign newdata_o = rx_nd_q;
  assign rxerror_o = rx_err_q;

endmodule

// File: tb/tb_rs485_uart_link.sv
// Testbench for rs485_uart_link with g_ClkDiv=4, g_Guard=1.
// Directed vectors: TX framing, RX good/bad frames, glitch rejection,
// busy-time request rejection with loopback echo, and mid-frame reset.
module tb_rs485_uart_link;

  localparam int CLKDIV = 4;
  localparam int GUARD  = 1;
  localparam int TOTAL  = (10 + 2 * GUARD) * CLKDIV;

  logic       clk;
  logic       rst;
  ckrs_t      clkrs;
  logic [7:0] data_i;
  logic       txstart;
  logic       txbusy_o;
  logic       tx_o;
  logic       de_o;
  logic       rx_line;
  logic       rx_drv;
  logic       loop_en;
  logic [7:0] data_ob8;
  logic       newdata_o;
  logic       rxerror_o;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int nd_cnt = 0;
  int er_cnt = 0;
  int nd_last = 0;
  int er_last = 0;

  assign clkrs.clk   = clk;
  assign clkrs.reset = rst;
  assign rx_line     = loop_en ? tx_o : rx_drv;

  rs485_uart_link #(
    .g_ClkDiv(CLKDIV),
    .g_Guard (GUARD)
  ) dut (
    .ClkRs_ix (clkrs),
    .data_ib8 (data_i),
    .txstart_i(txstart),
    .txbusy_o (txbusy_o),
    .Tx_o     (tx_o),
    .de_o     (de_o),
    .Rx_i     (rx_line),
    .data_ob8 (data_ob8),
    .newdata_o(newdata_o),
    .rxerror_o(rxerror_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (newdata_o) begin
      nd_cnt  <= nd_cnt + 1;
      nd_last <= cyc;
    end
    if (rxerror_o) begin
      er_cnt  <= er_cnt + 1;
      er_last <= cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Send one byte and check every cycle of the frame on Tx_o/de_o/txbusy_o.
  // With poke set, a second request (8'h11) is raised while busy.
  task automatic send_check(input logic [7:0] b, input string tag, input bit poke);
    logic [9:0] exp_bits;
    logic [3:0] got;
    int de_n, busy_n, idle_bad, pos;
    exp_bits = {1'b1, b, 1'b0};
    got      = '0;
    de_n     = 0;
    busy_n   = 0;
    idle_bad = 0;
    @(negedge clk);
    data_i  = b;
    txstart = 1'b1;
    @(negedge clk);
    txstart = 1'b0;
    data_i  = 8'h00;
    for (int c = 0; c < TOTAL; c++) begin
      if (de_o) de_n++;
      if (txbusy_o) busy_n++;
      pos = c - GUARD * CLKDIV;
      if (pos < 0 || pos >= 10 * CLKDIV) begin
        if (tx_o !== 1'b1) idle_bad++;
      end else begin
        got[pos % CLKDIV] = tx_o;
        if (pos % CLKDIV == CLKDIV - 1)
          check_val($sformatf("%s_bit%0d", tag, pos / CLKDIV), 32'(got),
                    32'({4{exp_bits[pos / CLKDIV]}}));
      end
      if (poke) begin
        if (c == 10) begin
          data_i  = 8'h11;
          txstart = 1'b1;
        end else if (c == 11) begin
          data_i  = 8'h00;
          txstart = 1'b0;
        end
      end
      @(negedge clk);
    end
    check_val({tag, "_de_cycles"}, de_n, TOTAL);
    check_val({tag, "_busy_cycles"}, busy_n, TOTAL);
    check_val({tag, "_guard_tx_high"}, idle_bad, 0);
    check_val({tag, "_end_busy"}, 32'(txbusy_o), 0);
    check_val({tag, "_end_de"}, 32'(de_o), 0);
    check_val({tag, "_end_tx"}, 32'(tx_o), 1);
  endtask

  // Drive one 8N1 frame on the RX line starting at the current negedge.
  task automatic rx_frame(input logic [7:0] b, input logic stopb);
    logic [9:0] f;
    f = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (CLKDIV) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    int nd0, er0, k, lat, busy_seen;
    rst     = 1'b1;
    data_i  = 8'h00;
    txstart = 1'b0;
    rx_drv  = 1'b1;
    loop_en = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_tx", 32'(tx_o), 1);
    check_val("rst_de", 32'(de_o), 0);
    check_val("rst_busy", 32'(txbusy_o), 0);
    check_val("rst_newdata", 32'(newdata_o), 0);
    check_val("rst_rxerror", 32'(rxerror_o), 0);
    check_val("rst_data", 32'(data_ob8), 32'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Transmit 8'hA5: 0,1,0,1,0,0,1,0,1,1 each held 4 cycles, 48 busy cycles
    send_check(8'hA5, "txA5", 1'b0);
    repeat (4) @(negedge clk);

    // Good RX frame 8'h3C
    nd0 = nd_cnt;
    er0 = er_cnt;
    k   = cyc;
    rx_frame(8'h3C, 1'b1);
    repeat (6) @(negedge clk);
    lat = nd_last - k;
    check_val("rx3C_newdata_cnt", nd_cnt - nd0, 1);
    check_val("rx3C_err_cnt", er_cnt - er0, 0);
    check_val("rx3C_data", 32'(data_ob8), 32'h3C);
    check_val("rx3C_latency_ok", 32'(lat >= 40 && lat <= 42), 1);

    // Framing error: byte 8'hC3 with a low stop bit must not reach data_ob8
    nd0 = nd_cnt;
    er0 = er_cnt;
    k   = cyc;
    rx_frame(8'hC3, 1'b0);
    repeat (6) @(negedge clk);
    lat = er_last - k;
    check_val("rxbad_err_cnt", er_cnt - er0, 1);
    check_val("rxbad_newdata_cnt", nd_cnt - nd0, 0);
    check_val("rxbad_data_kept", 32'(data_ob8), 32'h3C);
    check_val("rxbad_latency_ok", 32'(lat >= 40 && lat <= 42), 1);

    // Same frame content with bad stop bit: still an error, data kept
    nd0 = nd_cnt;
    er0 = er_cnt;
    rx_frame(8'h3C, 1'b0);
    repeat (6) @(negedge clk);
    check_val("rx3Cbad_err_cnt", er_cnt - er0, 1);
    check_val("rx3Cbad_newdata_cnt", nd_cnt - nd0, 0);
    check_val("rx3Cbad_data_kept", 32'(data_ob8), 32'h3C);

    // One-cycle glitch, then a real frame right after the glitch window
    nd0 = nd_cnt;
    er0 = er_cnt;
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (CLKDIV / 2 + 3) @(negedge clk);
    check_val("glitch_newdata_cnt", nd_cnt - nd0, 0);
    check_val("glitch_err_cnt", er_cnt - er0, 0);
    rx_frame(8'h96, 1'b1);
    repeat (6) @(negedge clk);
    check_val("post_glitch_newdata_cnt", nd_cnt - nd0, 1);
    check_val("post_glitch_err_cnt", er_cnt - er0, 0);
    check_val("post_glitch_data", 32'(data_ob8), 32'h96);

    // Loopback: request 8'h11 while sending 8'h22; echo must be ignored
    loop_en = 1'b1;
    nd0 = nd_cnt;
    er0 = er_cnt;
    send_check(8'h22, "lb22", 1'b1);
    busy_seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (txbusy_o) busy_seen++;
      @(negedge clk);
    end
    check_val("lb_no_queued_tx", busy_seen, 0);
    check_val("lb_echo_newdata", nd_cnt - nd0, 0);
    check_val("lb_echo_err", er_cnt - er0, 0);
    check_val("lb_data_kept", 32'(data_ob8), 32'h96);
    loop_en = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during data bit 3 of 8'h81 (bit 3 is 0 on the line)
    @(negedge clk);
    data_i  = 8'h81;
    txstart = 1'b1;
    @(negedge clk);
    txstart = 1'b0;
    data_i  = 8'h00;
    repeat (GUARD * CLKDIV + CLKDIV + 3 * CLKDIV + 1) @(negedge clk);
    check_val("mid_pre_tx_bit3", 32'(tx_o), 0);
    check_val("mid_pre_busy", 32'(txbusy_o), 1);
    rst = 1'b1;
    #1;
    check_val("mid_rst_tx", 32'(tx_o), 1);
    check_val("mid_rst_de", 32'(de_o), 0);
    check_val("mid_rst_busy", 32'(txbusy_o), 0);
    check_val("mid_rst_data", 32'(data_ob8), 32'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean frame after reset
    send_check(8'h5A, "tx5A", 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
